deskew_reorder_rx: RTL and testbench
====================================

Name: deskew_reorder_rx

Overview:
- Multi-lane receive deskew with per-lane circular buffers, alignment-marker-based lane alignment, logical lane reordering and continuous skew monitoring.
- Sits after per-lane block lock / alignment-marker lock.
- Delivers LANE_N blocks per cycle, aligned on marker boundaries and in logical lane order.
- Successor of the fixed-function per-lane deskew: adds configurable buffer depth, lane-ID remap, overflow/skew error detection and an explicit alignment FSM.

Parameters:
LANE_N, 4, number of physical lanes
BLOCK_W, 66, block width in bits
DEPTH, 32, entries per lane buffer; power of 2, >= MAX_SKEW_BLOCK_N+2
MAX_SKEW_BLOCK_N, 27, max tolerated marker arrival spread in cycles
LANE_ID_W, $clog2(LANE_N), width of decoded lane ID

Ports:
clk  in  1  clock
nreset  in  1  synchronous active-low reset
valid_i  in  LANE_N  per-lane block valid (signal ok and block lock)
am_v_i  in  LANE_N  per-lane: current block is an alignment marker
am_lock_v_i  in  LANE_N  per-lane marker lock held
am_lock_lost_v_i  in  LANE_N  per-lane marker lock lost pulse
lane_id_i  in  LANE_N*LANE_ID_W  per-lane logical lane ID decoded from marker; sampled when am_v_i[l]
data_i  in  LANE_N*BLOCK_W  per-lane block data
data_v_o  out  1  data_o valid
data_o  out  LANE_N*BLOCK_W  deskewed data; slice k = logical lane k
am_v_o  out  1  data_o carries aligned markers on all lanes
aligned_o  out  1  FSM in ALIGNED
skew_err_o  out  1  one-cycle pulse: skew, overflow or marker mismatch
lane_id_err_o  out  1  one-cycle pulse: captured IDs not a permutation

Behaviour:
- Reset (nreset=0 at a clk edge):
  - FSM to IDLE.
  - All pointers, marked flags and skew counter cleared.
  - All outputs 0.
  - Applies mid-operation; buffered data is discarded.
- Buffer entries are {am_flag, data}. Each lane has a write pointer and a read pointer of $clog2(DEPTH)+1 bits.
  - empty = pointers equal.
  - full = MSBs differ, rest equal.
- IDLE:
  - No writes; pointers held at 0.
  - Go to WAIT_AM when &(am_lock_v_i & valid_i) and no lock-lost pulse.
- WAIT_AM:
  - A lane drops blocks until valid_i[l] & am_v_i[l]. That marker block is written at entry 0; the lane sets its marked flag and captures lane_id_i[l].
  - Once marked, the lane writes every valid block.
  - The skew counter starts at 0 on the first marked cycle and increments each cycle while any lane is unmarked.
  - Counter reaching MAX_SKEW_BLOCK_N+1 with a lane still unmarked: skew_err_o pulse, go to IDLE.
  - On the edge where the last lane becomes marked:
    - captured IDs are a permutation of 0..LANE_N-1: go to ALIGNED;
    - otherwise: lane_id_err_o pulse, go to IDLE.
  - Markers on all lanes in the same cycle: skew 0, go straight to ALIGNED.
- ALIGNED:
  - Write on valid_i[l].
  - Read all lanes together in a cycle where every lane is non-empty; no partial reads.
  - Output registered: data_v_o=1 on the cycle after the read.
  - data_o slice k = head of the physical lane whose captured ID == k.
  - am_v_o = AND of the read am_flags.
  - Read with some but not all am_flags set: skew_err_o pulse, go to IDLE. data_v_o for that read is suppressed.
  - Write to a full lane: skew_err_o pulse, go to IDLE.
- Latency with zero skew: markers written on edge T, read in cycle T+1, data_v_o=1 with am_v_o=1 in cycle T+2.
- Any state, any lane showing am_lock_lost_v_i or ~am_lock_v_i: go to IDLE next edge, no error pulse. This takes priority over simultaneous skew or ID errors, which are suppressed.
- data_v_o, am_v_o and aligned_o are 0 in IDLE and WAIT_AM. data_o holds its last value when data_v_o=0.
- Error pulses last exactly one cycle. Re-acquisition through IDLE is automatic while lock is held.

Test Plan:
- Zero skew, identity IDs 0,1,2,3, markers on all lanes at cycle 10 -> aligned_o=1 from cycle 11; data_v_o=1 and am_v_o=1 at cycle 12; data_o equals the input blocks in lane order.
- Markers at cycles 10,13,15,20 with IDs 2,0,3,1 -> ALIGNED at edge 20; first output has am_v_o=1; data_o slice 0 = physical lane 1, slice 1 = lane 3, slice 2 = lane 0, slice 3 = lane 2. All later blocks stay aligned.
- Lane 3 marker arrives 28 cycles after lane 0 (MAX_SKEW_BLOCK_N=27) -> skew_err_o pulse at count 28; FSM returns to IDLE, then WAIT_AM.
- Captured IDs 0,1,1,3 -> lane_id_err_o pulse, no ALIGNED, outputs stay 0.
- While ALIGNED, lane 2 slips one block so a read sees am_flags 4'b1011 -> skew_err_o pulse, that data_v_o suppressed, aligned_o=0.
- nreset=0 mid-ALIGNED, and separately am_lock_lost_v_i[1] pulse coinciding with a marker mismatch -> all outputs 0, no error pulse; re-lock and alignment succeed afterwards.

Source files
------------

// File: rtl/deskew_reorder_rx.sv
// deskew_reorder_rx: per-lane marker-aligned deskew buffers with logical lane reorder and skew monitoring
module deskew_reorder_rx #(
    parameter int LANE_N           = 4,
    parameter int BLOCK_W          = 66,
    parameter int DEPTH            = 32,
    parameter int MAX_SKEW_BLOCK_N = 27,
    parameter int LANE_ID_W        = $clog2(LANE_N)
) (
    input  logic                        clk,
    input  logic                        nreset,
    input  logic [LANE_N-1:0]           valid_i,
    input  logic [LANE_N-1:0]           am_v_i,
    input  logic [LANE_N-1:0]           am_lock_v_i,
    input  logic [LANE_N-1:0]           am_lock_lost_v_i,
    input  logic [LANE_N*LANE_ID_W-1:0] lane_id_i,
    input  logic [LANE_N*BLOCK_W-1:0]   data_i,
    output logic                        data_v_o,
    output logic [LANE_N*BLOCK_W-1:0]   data_o,
    output logic                        am_v_o,
    output logic                        aligned_o,
    output logic                        skew_err_o,
    output logic                        lane_id_err_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(MAX_SKEW_BLOCK_N + 2);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_AM, S_ALIGNED} state_t;

    state_t                   r_state, w_state_nxt;
    logic [BLOCK_W:0]         r_mem [LANE_N][DEPTH];
    logic [AW:0]              r_wptr [LANE_N];
    logic [AW:0]              r_rptr [LANE_N];
    logic [LANE_ID_W-1:0]     r_id [LANE_N];
    logic [LANE_ID_W-1:0]     w_id_nxt [LANE_N];
    logic [BLOCK_W:0]         w_head [LANE_N];
    logic [LANE_N-1:0]        r_marked, w_new, w_wr, w_empty, w_full, w_flags, w_hit;
    logic [CW-1:0]            r_cnt;
    logic [LANE_N*BLOCK_W-1:0] w_dout, r_data;
    logic                     w_lock_bad, w_rd, w_mismatch, w_overflow, w_out_v;
    logic                     w_skew_err, w_id_err;
    logic                     r_data_v, r_am_v, r_skew_err, r_id_err;

    assign w_lock_bad = (|am_lock_lost_v_i) | ~(&am_lock_v_i);
    assign w_rd       = (r_state == S_ALIGNED) & ~(|w_empty);
    assign w_mismatch = w_rd & (|w_flags) & ~(&w_flags);
    assign w_overflow = (r_state == S_ALIGNED) & (|(valid_i & w_full));
    assign w_out_v    = w_rd & (w_state_nxt == S_ALIGNED);

    // Per-lane buffer status, write enables, marker/ID capture, ID coverage and logical reorder mux
    always_comb begin
        w_dout = '0;
        w_hit  = '0;
        for (int l = 0; l < LANE_N; l++) begin
            w_empty[l]  = r_wptr[l] == r_rptr[l];
            w_full[l]   = (r_wptr[l][AW] != r_rptr[l][AW]) && (r_wptr[l][AW-1:0] == r_rptr[l][AW-1:0]);
            w_head[l]   = r_mem[l][r_rptr[l][AW-1:0]];
            w_flags[l]  = w_head[l][BLOCK_W];
            w_new[l]    = valid_i[l] & am_v_i[l] & ~r_marked[l];
            w_id_nxt[l] = w_new[l] ? lane_id_i[l*LANE_ID_W +: LANE_ID_W] : r_id[l];
            w_wr[l]     = ~w_full[l] & valid_i[l] &
                          ((r_state == S_ALIGNED) | ((r_state == S_WAIT_AM) & (r_marked[l] | am_v_i[l])));
        end
        for (int k = 0; k < LANE_N; k++) begin
            for (int l = 0; l < LANE_N; l++) begin
                if (w_id_nxt[l] == LANE_ID_W'(k)) w_hit[k] = 1'b1;
                if (r_id[l] == LANE_ID_W'(k)) w_dout[k*BLOCK_W +: BLOCK_W] = w_head[l][BLOCK_W-1:0];
            end
        end
    end

    // Alignment FSM next state; lock loss overrides and silences every error
    always_comb begin
        w_state_nxt = r_state;
        w_skew_err  = 1'b0;
        w_id_err    = 1'b0;
        if (w_lock_bad) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: w_state_nxt = (&valid_i) ? S_WAIT_AM : S_IDLE;
                S_WAIT_AM: begin
                    if ((|r_marked) && (r_cnt == CW'(MAX_SKEW_BLOCK_N))) begin
                        w_skew_err  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (&(r_marked | w_new)) begin
                        w_id_err    = ~(&w_hit);
                        w_state_nxt = (&w_hit) ? S_ALIGNED : S_IDLE;
                    end
                end
                S_ALIGNED: begin
                    w_skew_err  = w_mismatch | w_overflow;
                    w_state_nxt = (w_mismatch | w_overflow) ? S_IDLE : S_ALIGNED;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!nreset) r_state <= S_IDLE;
        else r_state <= w_state_nxt;
    end

    // Pointers, marked flags, captured IDs and skew counter; all held clear while idle
    always_ff @(posedge clk) begin
        if (!nreset || r_state == S_IDLE) begin
            r_marked <= '0;
            r_cnt    <= '0;
            for (int l = 0; l < LANE_N; l++) begin
                r_wptr[l] <= '0;
                r_rptr[l] <= '0;
                r_id[l]   <= '0;
            end
        end else begin
            r_marked <= r_marked | w_new;
            if (r_state == S_WAIT_AM && (|r_marked)) r_cnt <= r_cnt + 1'b1;
            for (int l = 0; l < LANE_N; l++) begin
                r_id[l] <= w_id_nxt[l];
                if (w_wr[l]) r_wptr[l] <= r_wptr[l] + 1'b1;
                if (w_rd) r_rptr[l] <= r_rptr[l] + 1'b1;
            end
        end
    end

    // Buffer storage: {am_flag, data} per entry
    always_ff @(posedge clk) begin
        for (int l = 0; l < LANE_N; l++)
            if (w_wr[l]) r_mem[l][r_wptr[l][AW-1:0]] <= {am_v_i[l], data_i[l*BLOCK_W +: BLOCK_W]};
    end

    // Registered outputs; data holds between valid reads
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_data_v   <= 1'b0;
            r_am_v     <= 1'b0;
            r_data     <= '0;
            r_skew_err <= 1'b0;
            r_id_err   <= 1'b0;
        end else begin
            r_data_v   <= w_out_v;
            r_am_v     <= w_out_v & (&w_flags);
            r_skew_err <= w_skew_err;
            r_id_err   <= w_id_err;
            if (w_out_v) r_data <= w_dout;
        end
    end

    assign data_v_o      = r_data_v;
    assign am_v_o        = r_am_v;
    assign data_o        = r_data;
    assign aligned_o     = r_state == S_ALIGNED;
    assign skew_err_o    = r_skew_err;
    assign lane_id_err_o = r_id_err;
endmodule

// File: tb/tb_deskew_reorder_rx.sv
// tb_deskew_reorder_rx: directed deskew scenarios checked against a queue-level reference model
module tb_deskew_reorder_rx;
    localparam int LN = 4, BW = 66, DEPTH = 32, MAXS = 27, PER = 32;

    logic            clk = 1'b0, nreset;
    logic [LN-1:0]   valid_i, am_v_i, am_lock_v_i, am_lock_lost_v_i;
    logic [LN*2-1:0] lane_id_i;
    logic [LN*BW-1:0] data_i, data_o;
    logic            data_v_o, am_v_o, aligned_o, skew_err_o, lane_id_err_o;

    int n_vec = 0, n_bad = 0, n_skew = 0, n_ide = 0, n_al = 0, n_dv = 0;
    int skew [LN];
    int pmap [LN];
    logic [1:0] lid [LN];

    deskew_reorder_rx #(.LANE_N(LN), .BLOCK_W(BW), .DEPTH(DEPTH), .MAX_SKEW_BLOCK_N(MAXS)) dut (
        .clk(clk), .nreset(nreset), .valid_i(valid_i), .am_v_i(am_v_i),
        .am_lock_v_i(am_lock_v_i), .am_lock_lost_v_i(am_lock_lost_v_i),
        .lane_id_i(lane_id_i), .data_i(data_i), .data_v_o(data_v_o), .data_o(data_o),
        .am_v_o(am_v_o), .aligned_o(aligned_o), .skew_err_o(skew_err_o),
        .lane_id_err_o(lane_id_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [LN*BW-1:0] act, input logic [LN*BW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: per-lane FIFOs of {am, data}, mode 0 idle / 1 waiting for markers / 2 aligned
    int m_mode = 0, m_cyc = 0, m_first = 0;
    bit m_have = 0;
    logic [LN-1:0] m_marked = '0;
    logic [1:0] m_id [LN];
    logic [BW:0] q [LN][$];
    logic [LN*BW-1:0] e_data = '0;
    bit e_dv = 0, e_am = 0, e_skew = 0, e_ide = 0, e_al = 0;

    task automatic model_step();
        bit lockbad, rd, ovf, late;
        logic [LN-1:0] flags, seen;
        logic [BW:0] head [LN];
        m_cyc++;
        e_dv = 0; e_am = 0; e_skew = 0; e_ide = 0;
        lockbad = (|am_lock_lost_v_i) || !(&am_lock_v_i);
        if (!nreset) begin
            m_mode = 0;
            e_data = '0;
        end else if (m_mode == 0) begin
            if (!lockbad && &(am_lock_v_i & valid_i)) m_mode = 1;
        end else if (lockbad) begin
            m_mode = 0;
        end else if (m_mode == 1) begin
            late = m_have && (m_cyc - m_first > MAXS);
            for (int l = 0; l < LN; l++) begin
                if (valid_i[l] && (m_marked[l] || am_v_i[l])) begin
                    if (!m_marked[l]) begin
                        m_marked[l] = 1'b1;
                        m_id[l] = lane_id_i[l*2 +: 2];
                        if (!m_have) begin m_have = 1; m_first = m_cyc; end
                    end
                    q[l].push_back({am_v_i[l], data_i[l*BW +: BW]});
                end
            end
            if (late) begin
                e_skew = 1; m_mode = 0;
            end else if (&m_marked) begin
                seen = '0;
                for (int l = 0; l < LN; l++) seen[m_id[l]] = 1'b1;
                if (&seen) m_mode = 2;
                else begin e_ide = 1; m_mode = 0; end
            end
        end else begin
            rd = 1; ovf = 0; flags = '0;
            for (int l = 0; l < LN; l++) begin
                if (q[l].size() == 0) rd = 0;
                if (valid_i[l] && q[l].size() == DEPTH) ovf = 1;
            end
            if (rd) for (int l = 0; l < LN; l++) begin
                head[l] = q[l].pop_front();
                flags[l] = head[l][BW];
            end
            for (int l = 0; l < LN; l++) if (valid_i[l]) q[l].push_back({am_v_i[l], data_i[l*BW +: BW]});
            if ((rd && flags != '0 && flags != '1) || ovf) begin
                e_skew = 1; m_mode = 0;
            end else if (rd) begin
                e_dv = 1;
                e_am = &flags;
                for (int k = 0; k < LN; k++)
                    for (int l = 0; l < LN; l++)
                        if (m_id[l] == k) e_data[k*BW +: BW] = head[l][BW-1:0];
            end
        end
        if (m_mode == 0) begin
            for (int l = 0; l < LN; l++) q[l].delete();
            m_marked = '0;
            m_have = 0;
        end
        e_al = (m_mode == 2);
    endtask

    // Compare every cycle, shortly after the active edge
    always @(posedge clk) begin
        model_step();
        #1;
        chk("dv", data_v_o, e_dv);
        chk("am", am_v_o, e_am);
        chk("aligned", aligned_o, e_al);
        chk("skew_err", skew_err_o, e_skew);
        chk("id_err", lane_id_err_o, e_ide);
        chk("data", data_o, e_data);
    end

    // Stream cycle t: lane l carries block index t-skew[l]; every PER-th block is a marker
    task automatic tick(input int t, input logic rst_n, input logic [LN-1:0] lost);
        nreset = rst_n;
        valid_i = '1;
        am_lock_v_i = '1;
        am_lock_lost_v_i = lost;
        for (int l = 0; l < LN; l++) begin
            int b;
            b = t - skew[l];
            am_v_i[l] = (b >= 0) && (b % PER == 0);
            lane_id_i[l*2 +: 2] = lid[l];
            data_i[l*BW +: BW] = {lid[l], 32'(b), 32'(l)};
        end
        @(posedge clk);
        @(negedge clk);
        if (skew_err_o) n_skew++;
        if (lane_id_err_o) n_ide++;
        if (aligned_o) n_al++;
        if (data_v_o) n_dv++;
    endtask

    function automatic logic [LN*BW-1:0] exp_out(input int b);
        logic [LN*BW-1:0] r;
        for (int k = 0; k < LN; k++) r[k*BW +: BW] = {2'(k), 32'(b), 32'(pmap[k])};
        return r;
    endfunction

    task automatic restart();
        tick(-1000, 1'b0, '0);
        tick(-1000, 1'b0, '0);
        n_skew = 0; n_ide = 0; n_al = 0; n_dv = 0;
    endtask

    initial begin
        nreset = 1'b0;
        valid_i = '0; am_v_i = '0; am_lock_v_i = '0; am_lock_lost_v_i = '0;
        lane_id_i = '0; data_i = '0;
        skew = '{10, 10, 10, 10}; lid = '{0, 1, 2, 3}; pmap = '{0, 1, 2, 3};
        @(negedge clk);
        restart();
        chk("reset_aligned", aligned_o, 0);
        chk("reset_data", data_o, 0);
        for (int t = 0; t <= 40; t++) begin
            tick(t, 1'b1, '0);
            if (t == 9) chk("t1_aligned_pre", aligned_o, 0);
            if (t == 10) begin chk("t1_aligned", aligned_o, 1); chk("t1_dv_pre", data_v_o, 0); end
            if (t == 11) begin
                chk("t1_dv", data_v_o, 1); chk("t1_am", am_v_o, 1); chk("t1_data", data_o, exp_out(0));
            end
            if (t == 12) begin chk("t1_am_next", am_v_o, 0); chk("t1_data_next", data_o, exp_out(1)); end
        end
        chk("t1_errs", n_skew + n_ide, 0);

        skew = '{10, 13, 15, 20}; lid = '{2, 0, 3, 1}; pmap = '{1, 3, 0, 2};
        restart();
        for (int t = 0; t <= 70; t++) begin
            tick(t, 1'b1, '0);
            if (t == 19) chk("t2_aligned_pre", aligned_o, 0);
            if (t == 20) chk("t2_aligned", aligned_o, 1);
            if (t >= 21) begin
                chk("t2_dv", data_v_o, 1);
                chk("t2_am", am_v_o, ((t - 21) % PER) == 0);
                chk("t2_data", data_o, exp_out(t - 21));
            end
        end
        chk("t2_errs", n_skew, 0);

        skew = '{10, 12, 12, 38}; lid = '{0, 1, 2, 3}; pmap = '{0, 1, 2, 3};
        restart();
        for (int t = 0; t <= 50; t++) begin
            tick(t, 1'b1, '0);
            if (t == 37) chk("t3_skew_pre", skew_err_o, 0);
            if (t == 38) chk("t3_skew", skew_err_o, 1);
            if (t == 39) chk("t3_skew_post", skew_err_o, 0);
        end
        chk("t3_nskew", n_skew, 1);
        chk("t3_nal", n_al, 0);

        skew = '{10, 12, 12, 37};
        restart();
        for (int t = 0; t <= 45; t++) begin
            tick(t, 1'b1, '0);
            if (t == 37) chk("t3b_aligned", aligned_o, 1);
            if (t == 38) begin chk("t3b_am", am_v_o, 1); chk("t3b_data", data_o, exp_out(0)); end
        end
        chk("t3b_nskew", n_skew, 0);

        skew = '{10, 10, 10, 10}; lid = '{0, 1, 1, 3};
        restart();
        for (int t = 0; t <= 35; t++) begin
            tick(t, 1'b1, '0);
            if (t == 10) chk("t4_id_err", lane_id_err_o, 1);
            if (t == 11) chk("t4_id_err_post", lane_id_err_o, 0);
        end
        chk("t4_nide", n_ide, 1);
        chk("t4_nal", n_al, 0);
        chk("t4_ndv", n_dv, 0);

        lid = '{0, 1, 2, 3};
        restart();
        for (int t = 0; t <= 60; t++) begin
            if (t == 20) skew[2] = 11;
            tick(t, 1'b1, '0);
            if (t == 42) begin chk("t5_dv_pre", data_v_o, 1); chk("t5_aligned_pre", aligned_o, 1); end
            if (t == 43) begin
                chk("t5_skew", skew_err_o, 1); chk("t5_dv", data_v_o, 0); chk("t5_aligned", aligned_o, 0);
            end
        end
        chk("t5_nskew", n_skew, 1);

        skew = '{10, 10, 10, 10};
        restart();
        for (int t = 0; t <= 50; t++) begin
            tick(t, (t == 25) ? 1'b0 : 1'b1, '0);
            if (t == 25) begin
                chk("t6a_dv", data_v_o, 0); chk("t6a_am", am_v_o, 0); chk("t6a_aligned", aligned_o, 0);
                chk("t6a_data", data_o, 0);
            end
            if (t == 42) chk("t6a_realign", aligned_o, 1);
            if (t == 43) begin chk("t6a_am_re", am_v_o, 1); chk("t6a_data_re", data_o, exp_out(32)); end
        end
        chk("t6a_errs", n_skew + n_ide, 0);

        restart();
        for (int t = 0; t <= 80; t++) begin
            if (t == 20) skew[2] = 11;
            tick(t, 1'b1, (t == 43) ? 4'b0010 : 4'b0000);
            if (t == 43) begin
                chk("t6b_skew", skew_err_o, 0); chk("t6b_aligned", aligned_o, 0); chk("t6b_dv", data_v_o, 0);
            end
            if (t == 75) chk("t6b_realign", aligned_o, 1);
            if (t == 76) begin chk("t6b_am_re", am_v_o, 1); chk("t6b_data_re", data_o, exp_out(64)); end
        end
        chk("t6b_nskew", n_skew, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
